// File: rtl/div_32_bit_seq_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// iteration count, divide-by-zero quotient and magnitude helpers.
package div_32_bit_seq_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    function automatic logic [DIV_WIDTH-1:0] neg32(input logic [DIV_WIDTH-1:0] x);
        return ~x + 32'd1;
    endfunction

    // Magnitude of -2^31 wraps to 32'h8000_0000, read as unsigned 2^31.
    function automatic logic [DIV_WIDTH-1:0] abs32(input logic [DIV_WIDTH-1:0] x);
        return x[DIV_WIDTH-1] ? neg32(x) : x;
    endfunction

endpackage

// File: rtl/adder_32_bit.sv
// 32-bit adder with carry in/out used for the partial-remainder add/subtract.
module adder_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    assign {cout, sum} = 33'(a) + 33'(b) + 33'(cin);

endmodule

// File: rtl/div_32_bit_seq.sv
// Multi-cycle signed non-restoring divider: quotient to LO, remainder to HI.
// One add/subtract of the 33-bit partial remainder per cycle through adder_32_bit.
module div_32_bit_seq
    import div_32_bit_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned ITERS = DIV_ITERS
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(ITERS);

    div_state_e       state, state_nxt;
    logic [WIDTH:0]   p, p_nxt;
    logic [WIDTH-1:0] q, q_nxt;
    logic [WIDTH-1:0] d, d_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic             sign_q, sign_q_nxt;
    logic             sign_r, sign_r_nxt;
    logic             dz, dz_nxt;
    logic             busy_nxt, done_nxt, dbz_nxt;
    logic [WIDTH-1:0] quot_nxt, rem_nxt, rem_mag;

    logic [WIDTH:0]   p_sh;
    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_cout;

    // Adder operand select: iteration add/sub, or final restore in FIX.
    always_comb begin
        p_sh = {p[WIDTH-1:0], q[WIDTH-1]};
        if (state == FIX) begin
            add_a   = p[WIDTH-1:0];
            add_b   = d;
            add_cin = 1'b0;
        end else begin
            add_a   = p_sh[WIDTH-1:0];
            add_b   = p[WIDTH] ? d : ~d;
            add_cin = ~p[WIDTH];
        end
    end

    adder_32_bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state and next-register logic.
    always_comb begin
        state_nxt  = state;
        p_nxt      = p;
        q_nxt      = q;
        d_nxt      = d;
        count_nxt  = count;
        sign_q_nxt = sign_q;
        sign_r_nxt = sign_r;
        dz_nxt     = dz;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        dbz_nxt    = div_by_zero;
        quot_nxt   = quotient;
        rem_nxt    = remainder;
        rem_mag    = p[WIDTH-1:0];

        case (state)
            IDLE: begin
                if (start) begin
                    q_nxt      = abs32(dividend);
                    d_nxt      = abs32(divisor);
                    p_nxt      = '0;
                    sign_q_nxt = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    sign_r_nxt = dividend[WIDTH-1];
                    count_nxt  = '0;
                    busy_nxt   = 1'b1;
                    dz_nxt     = (divisor == '0);
                    state_nxt  = (divisor == '0) ? FIX : ITER;
                end
            end
            ITER: begin
                // Bit 32 of the 33-bit sum: operand extension bit is 1 on subtract.
                p_nxt     = {p_sh[WIDTH] ^ ~p[WIDTH] ^ add_cout, add_sum};
                q_nxt     = {q[WIDTH-2:0], ~p_nxt[WIDTH]};
                count_nxt = count + CW'(1);
                if (count == CW'(ITERS - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                done_nxt  = 1'b1;
                state_nxt = DONE;
                if (dz) begin
                    quot_nxt = DIV_ZERO_QUOT;
                    rem_nxt  = sign_r ? neg32(q) : q;
                    dbz_nxt  = 1'b1;
                end else begin
                    rem_mag  = p[WIDTH] ? add_sum : p[WIDTH-1:0];
                    quot_nxt = sign_q ? neg32(q) : q;
                    rem_nxt  = sign_r ? neg32(rem_mag) : rem_mag;
                    dbz_nxt  = 1'b0;
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            p           <= '0;
            q           <= '0;
            d           <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            state       <= state_nxt;
            p           <= p_nxt;
            q           <= q_nxt;
            d           <= d_nxt;
            count       <= count_nxt;
            sign_q      <= sign_q_nxt;
            sign_r      <= sign_r_nxt;
            dz          <= dz_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            div_by_zero <= dbz_nxt;
            quotient    <= quot_nxt;
            remainder   <= rem_nxt;
        end
    end

endmodule

// File: tb/tb_div_32_bit_seq.sv
// Directed bench for div_32_bit_seq: signed cases, overflow, divide by zero,
// ignored start while busy, and mid-operation clear.
module tb_div_32_bit_seq;

    logic        clk;
    logic        clr;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;
    int n;
    int seen_done;

    div_32_bit_seq dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Launch one division, wait for done, check latency, results and hold.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input logic edz, input int elat);
        int cnt;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ":busy_after_start"}, 32'(busy), 32'd1);
        cnt = 0;
        while (!done && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, ":latency"}, 32'(cnt), 32'(elat));
        check({tag, ":quotient"}, quotient, eq);
        check({tag, ":remainder"}, remainder, er);
        check({tag, ":div_by_zero"}, 32'(div_by_zero), 32'(edz));
        @(posedge clk); #1;
        check({tag, ":done_one_cycle"}, 32'(done), 32'd0);
        check({tag, ":busy_drop"}, 32'(busy), 32'd0);
        check({tag, ":quotient_hold"}, quotient, eq);
    endtask

    initial begin
        clr      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset:busy", 32'(busy), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        check("reset:quotient", quotient, 32'd0);
        check("reset:remainder", remainder, 32'd0);
        check("reset:div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        clr = 1'b0;

        run_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        run_div("-100/7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
        run_div("100/-7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 33);
        run_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
        run_div("min/2", 32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 1'b0, 33);
        run_div("55/0", 32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b1, 1);
        run_div("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

        // Second start during iteration 5 must be ignored.
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd10;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        repeat (5) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        dividend = 32'd5;
        divisor  = 32'd1;
        start    = 1'b1;
        @(posedge clk); #1;
        n++;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        check("ignore:busy", 32'(busy), 32'd1);
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ignore:latency", 32'(n), 32'd33);
        check("ignore:quotient", quotient, 32'd100);
        check("ignore:remainder", remainder, 32'd0);
        @(posedge clk); #1;
        check("ignore:done_drop", 32'(done), 32'd0);

        // Clear at iteration 10 aborts with no done pulse.
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd10;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        #1;
        check("clr:busy", 32'(busy), 32'd0);
        check("clr:done", 32'(done), 32'd0);
        check("clr:quotient", quotient, 32'd0);
        check("clr:remainder", remainder, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        seen_done = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) seen_done = 1;
        end
        check("clr:no_done_pulse", 32'(seen_done), 32'd0);
        check("clr:idle_busy", 32'(busy), 32'd0);

        run_div("77/8", 32'd77, 32'd8, 32'd9, 32'd5, 1'b0, 33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
